// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and widths for the 8259-style INTA sequencer.
package pic_inta_sequencer_pkg;

  localparam int unsigned NUM_IR  = 8;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned BASE_W  = 5;
  localparam int unsigned VEC_W   = BASE_W + LEVEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_e;

  // Vector byte driven on the second INTA pulse: T7..T3 from ICW2, level in T2..T0.
  typedef struct packed {
    logic [BASE_W-1:0]  base;
    logic [LEVEL_W-1:0] level;
  } vector_t;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: level lowest+1 has rank 0 (highest), lowest has rank 7.
module pic_priority_resolver
  import pic_inta_sequencer_pkg::*;
(
  input  logic [NUM_IR-1:0]  req,
  input  logic [LEVEL_W-1:0] lowest,
  output logic               valid_c,
  output logic [LEVEL_W-1:0] level_c,
  output logic [LEVEL_W-1:0] rank_c
);

  logic [LEVEL_W-1:0] cand;

  // Scan from lowest rank to highest so the highest-ranked set bit wins last.
  always_comb begin
    valid_c = 1'b0;
    level_c = '0;
    rank_c  = '0;
    cand    = '0;
    for (int r = NUM_IR - 1; r >= 0; r--) begin
      cand = lowest + LEVEL_W'(r + 1);
      if (req[cand]) begin
        valid_c = 1'b1;
        level_c = cand;
        rank_c  = LEVEL_W'(r);
      end
    end
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU side of the interrupt path: INT generation, two-pulse INTA handshake,
// ISR bookkeeping, vector drive and EOI / rotation handling.
module pic_inta_sequencer
  import pic_inta_sequencer_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7,
  parameter logic [LEVEL_W-1:0] ROTATE_RESET   = 3'd7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inta_n,
  input  logic [NUM_IR-1:0]  irr,
  input  logic [BASE_W-1:0]  icw2_base,
  input  logic               aeoi,
  input  logic               rotate_en,
  input  logic               eoi_ns,
  input  logic               eoi_sp,
  input  logic [LEVEL_W-1:0] eoi_level,
  output logic               int_req,
  output logic               freeze,
  output logic [NUM_IR-1:0]  clear_interrupt_request,
  output logic [NUM_IR-1:0]  isr,
  output logic [VEC_W-1:0]   data_out,
  output logic               data_out_en
);

  ack_state_e         state_q, state_d;
  logic               inta_prev_q;
  logic [LEVEL_W-1:0] lowest_q, lowest_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               spurious_q, spurious_d;
  logic               int_req_d, freeze_d, data_out_en_d;
  logic [NUM_IR-1:0]  clear_d, isr_d;
  logic [VEC_W-1:0]   data_out_d;

  logic               fall_c, rise_c;
  logic               irr_valid_c, isr_valid_c;
  logic [LEVEL_W-1:0] irr_level_c, isr_level_c, irr_rank_c, isr_rank_c;
  vector_t            vec_c;

  assign fall_c = inta_prev_q & ~inta_n;
  assign rise_c = ~inta_prev_q & inta_n;
  assign vec_c  = '{base: icw2_base, level: level_q};

  pic_priority_resolver u_irr_res (
    .req     (irr),
    .lowest  (lowest_q),
    .valid_c (irr_valid_c),
    .level_c (irr_level_c),
    .rank_c  (irr_rank_c)
  );

  pic_priority_resolver u_isr_res (
    .req     (isr),
    .lowest  (lowest_q),
    .valid_c (isr_valid_c),
    .level_c (isr_level_c),
    .rank_c  (isr_rank_c)
  );

  // Next-state and next-output logic; EOI clears are applied before the ISR set.
  always_comb begin
    state_d       = state_q;
    int_req_d     = int_req;
    freeze_d      = freeze;
    clear_d       = '0;
    isr_d         = isr;
    data_out_d    = data_out;
    data_out_en_d = data_out_en;
    lowest_d      = lowest_q;
    level_d       = level_q;
    spurious_d    = spurious_q;

    if (eoi_sp) begin
      isr_d[eoi_level] = 1'b0;
      if (rotate_en) lowest_d = eoi_level;
    end else if (eoi_ns && isr_valid_c) begin
      isr_d[isr_level_c] = 1'b0;
      if (rotate_en) lowest_d = isr_level_c;
    end

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d   = ACK1;
          int_req_d = 1'b0;
          freeze_d  = 1'b1;
          if (irr_valid_c) begin
            level_d              = irr_level_c;
            spurious_d           = 1'b0;
            isr_d[irr_level_c]   = 1'b1;
            clear_d[irr_level_c] = 1'b1;
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end else begin
          int_req_d = irr_valid_c && (!isr_valid_c || (irr_rank_c < isr_rank_c));
        end
      end
      ACK1: begin
        if (rise_c) state_d = WAIT2;
      end
      WAIT2: begin
        if (fall_c) begin
          state_d       = ACK2;
          data_out_d    = vec_c;
          data_out_en_d = 1'b1;
        end
      end
      ACK2: begin
        if (rise_c) begin
          state_d       = IDLE;
          data_out_en_d = 1'b0;
          freeze_d      = 1'b0;
          if (aeoi && !spurious_q) begin
            isr_d[level_q] = 1'b0;
            if (rotate_en) lowest_d = level_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                 <= IDLE;
      inta_prev_q             <= 1'b1;
      lowest_q                <= ROTATE_RESET;
      level_q                 <= '0;
      spurious_q              <= 1'b0;
      int_req                 <= 1'b0;
      freeze                  <= 1'b0;
      clear_interrupt_request <= '0;
      isr                     <= '0;
      data_out                <= '0;
      data_out_en             <= 1'b0;
    end else begin
      state_q                 <= state_d;
      inta_prev_q             <= inta_n;
      lowest_q                <= lowest_d;
      level_q                 <= level_d;
      spurious_q              <= spurious_d;
      int_req                 <= int_req_d;
      freeze                  <= freeze_d;
      clear_interrupt_request <= clear_d;
      isr                     <= isr_d;
      data_out                <= data_out_d;
      data_out_en             <= data_out_en_d;
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios plus random traffic
// compared every cycle against a rank-arithmetic reference model.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, inta_n, aeoi, rotate_en, eoi_ns, eoi_sp;
  logic [7:0] irr;
  logic [4:0] icw2_base;
  logic [2:0] eoi_level;
  logic       int_req, freeze, data_out_en;
  logic [7:0] clear_interrupt_request, isr, data_out;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int       m_phase;
  bit       m_prev, m_spur, m_int, m_frz, m_den;
  bit [2:0] m_low, m_lvl;
  bit [7:0] m_clr, m_isr, m_dout;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.SPURIOUS_LEVEL(3'd7), .ROTATE_RESET(3'd7)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .inta_n                  (inta_n),
    .irr                     (irr),
    .icw2_base               (icw2_base),
    .aeoi                    (aeoi),
    .rotate_en               (rotate_en),
    .eoi_ns                  (eoi_ns),
    .eoi_sp                  (eoi_sp),
    .eoi_level               (eoi_level),
    .int_req                 (int_req),
    .freeze                  (freeze),
    .clear_interrupt_request (clear_interrupt_request),
    .isr                     (isr),
    .data_out                (data_out),
    .data_out_en             (data_out_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rank_of(input int lvl, input int low);
    return (lvl - low - 1 + 16) % 8;
  endfunction

  // Level with the smallest rank among set bits, or -1 if none.
  function automatic int best(input bit [7:0] v, input int low);
    int b = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (b < 0 || rank_of(i, low) < rank_of(b, low))) b = i;
    return b;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 1'b1; m_spur = 1'b0; m_int = 1'b0; m_frz = 1'b0;
    m_den = 1'b0; m_low = 3'd7; m_lvl = 3'd0; m_clr = '0; m_isr = '0; m_dout = '0;
  endtask

  task automatic model_step();
    bit       fall, rise;
    bit [7:0] n_isr;
    bit [2:0] n_low;
    int       w, t;
    fall  = m_prev && !inta_n;
    rise  = !m_prev && inta_n;
    n_isr = m_isr;
    n_low = m_low;
    m_clr = '0;
    w = best(irr, m_low);
    t = best(m_isr, m_low);
    if (eoi_sp) begin
      n_isr[eoi_level] = 1'b0;
      if (rotate_en) n_low = eoi_level;
    end else if (eoi_ns && t >= 0) begin
      n_isr[t] = 1'b0;
      if (rotate_en) n_low = 3'(t);
    end
    case (m_phase)
      0: begin
        if (fall) begin
          m_int = 1'b0; m_frz = 1'b1; m_phase = 1;
          if (w < 0) begin
            m_spur = 1'b1; m_lvl = 3'd7;
          end else begin
            m_spur = 1'b0; m_lvl = 3'(w); n_isr[w] = 1'b1; m_clr[w] = 1'b1;
          end
        end else begin
          m_int = (w >= 0) && (t < 0 || rank_of(w, m_low) < rank_of(t, m_low));
        end
      end
      1: if (rise) m_phase = 2;
      2: if (fall) begin
        m_dout = {icw2_base, m_lvl}; m_den = 1'b1; m_phase = 3;
      end
      default: if (rise) begin
        m_den = 1'b0; m_frz = 1'b0; m_phase = 0;
        if (aeoi && !m_spur) begin
          n_isr[m_lvl] = 1'b0;
          if (rotate_en) n_low = m_lvl;
        end
      end
    endcase
    m_isr  = n_isr;
    m_low  = n_low;
    m_prev = inta_n;
  endtask

  task automatic compare_all();
    check("int_req", int_req, m_int);
    check("freeze", freeze, m_frz);
    check("clear", clear_interrupt_request, m_clr);
    check("isr", isr, m_isr);
    check("data_out", data_out, m_dout);
    check("data_out_en", data_out_en, m_den);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse(input logic v);
    inta_n = v;
    cyc();
  endtask

  task automatic ack_pair(input logic [7:0] req);
    irr = req;
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
  endtask

  initial begin
    reset_n = 1'b0; inta_n = 1'b1; irr = '0; icw2_base = 5'b01000;
    aeoi = 1'b0; rotate_en = 1'b0; eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = '0;
    model_reset();
    cyc();
    cyc();
    check("rst_isr", isr, 8'h00);
    check("rst_dout", data_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic acknowledge of irr=0x24 with base 0x08
    irr = 8'h24;
    cyc();
    check("t1_int", int_req, 1'b1);
    pulse(1'b0);
    check("t1_clr", clear_interrupt_request, 8'h04);
    check("t1_isr", isr, 8'h04);
    check("t1_frz", freeze, 1'b1);
    irr = 8'h20;
    cyc();
    check("t1_clr_once", clear_interrupt_request, 8'h00);
    pulse(1'b1);
    check("t1_den_wait", data_out_en, 1'b0);
    pulse(1'b0);
    check("t1_vec", data_out, 8'h42);
    check("t1_den", data_out_en, 1'b1);
    pulse(1'b1);
    check("t1_den_off", data_out_en, 1'b0);

    // Lower-priority request does not interrupt the serviced level
    cyc();
    cyc();
    check("t2_nested", int_req, 1'b0);

    // Spurious acknowledge
    irr = 8'h00; icw2_base = 5'b11111;
    pulse(1'b0);
    check("t3_isr", isr, 8'h04);
    check("t3_clr", clear_interrupt_request, 8'h00);
    pulse(1'b1);
    pulse(1'b0);
    check("t3_vec", data_out, 8'hFF);
    pulse(1'b1);

    // Non-specific EOI releases the pending lower request
    irr = 8'h20; icw2_base = 5'b01000;
    eoi_ns = 1'b1;
    cyc();
    eoi_ns = 1'b0;
    check("t2_eoi_isr", isr, 8'h00);
    cyc();
    check("t2_eoi_int", int_req, 1'b1);

    // AEOI with rotation
    aeoi = 1'b1; rotate_en = 1'b1;
    ack_pair(8'h01);
    check("t4_aeoi_isr", isr, 8'h00);
    irr = 8'h03;
    cyc();
    pulse(1'b0);
    check("t4_rot_clr", clear_interrupt_request, 8'h02);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);

    // Specific EOI and same-cycle EOI precedence
    aeoi = 1'b0; rotate_en = 1'b0;
    ack_pair(8'h02);
    ack_pair(8'h08);
    check("t5_isr", isr, 8'h0A);
    eoi_sp = 1'b1; eoi_level = 3'd3;
    cyc();
    eoi_sp = 1'b0;
    check("t5_eoi_sp", isr, 8'h02);
    ack_pair(8'h08);
    eoi_ns = 1'b1; eoi_sp = 1'b1; eoi_level = 3'd1;
    cyc();
    eoi_ns = 1'b0; eoi_sp = 1'b0;
    check("t5_both", isr, 8'h08);

    // Asynchronous reset during WAIT2
    irr = 8'h10;
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t6_frz", freeze, 1'b0);
    check("t6_isr", isr, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    pulse(1'b0);
    check("t6_fresh_frz", freeze, 1'b1);
    check("t6_fresh_clr", clear_interrupt_request, 8'h10);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);

    // Random traffic, including glitches, EOI collisions and occasional resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) inta_n = ~inta_n;
      if ($urandom_range(0, 5) == 0) irr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) irr = '0;
      eoi_ns    = ($urandom_range(0, 11) == 0);
      eoi_sp    = ($urandom_range(0, 13) == 0);
      eoi_level = 3'($urandom);
      if ($urandom_range(0, 49) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 49) == 0) rotate_en = ~rotate_en;
      if ($urandom_range(0, 99) == 0) icw2_base = 5'($urandom);
      reset_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
